bus_slave_fifo: RTL and testbench

//  Slave endpoint of the req/gnt bus. Sits directly downstream of a bus master driver.

---
 rtl/bus_pkg.sv | 18 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/bus_slave_fifo.sv | 109 ++++++++++
 tb/tb_bus_slave_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and widths for the req/gnt bus slave: transfer record and slave FSM states.
package bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_xfer_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } slv_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; occupancy is tracked separately from the pointers
// so that full and empty are unambiguous at DEPTH entries.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    // Head is forced to zero while empty so the output is defined without resetting storage.
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bus_slave_fifo.sv
// Req/gnt bus slave: grants one transfer per handshake after a programmable delay, buffers it in
// a FWFT FIFO for a valid/ready consumer, and latches a sticky flag when the master drops req early.
module bus_slave_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int GNT_DELAY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      data,
    output logic                   gnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   proto_err
);

    localparam logic [3:0] DLY = 4'(GNT_DELAY);

    slv_state_e r_state;
    slv_state_e w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       r_gnt;
    logic       r_proto_err;
    logic       w_err_set;
    logic       w_push;
    logic       w_full;
    logic       w_empty;
    logic       w_cnt_done;
    bus_xfer_t  w_push_xfer;
    bus_xfer_t  w_head;

    assign w_push_xfer = {addr, data};
    // The counter saturates at DLY, so "reached DLY-1" and "already saturated" both satisfy this.
    assign w_cnt_done  = (DLY == 4'd0) || (({1'b0, r_cnt} + 5'd1) >= {1'b0, DLY});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_set   = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_cnt_nxt = '0;
                    if ((DLY == 4'd0) && !w_full) w_state_nxt = GRANT;
                    else                          w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt != DLY) w_cnt_nxt = r_cnt + 4'd1;
                if (!req) begin
                    w_state_nxt = IDLE;
                    w_err_set   = 1'b1;
                end else if (w_cnt_done && !w_full) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                w_state_nxt = IDLE;
                if (req) w_push    = 1'b1;
                else     w_err_set = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_gnt       <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= (w_state_nxt == GRANT);
            r_proto_err <= r_proto_err || w_err_set;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(bus_xfer_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_xfer),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign gnt       = r_gnt;
    assign proto_err = r_proto_err;
    assign out_valid = !w_empty;
    assign out_addr  = w_head.addr;
    assign out_data  = w_head.data;

endmodule

// File: tb/tb_bus_slave_fifo.sv
// Bench for bus_slave_fifo: three instances (grant delay 1, 3 and 0) sharing clock, reset,
// addr/data and out_ready, each with its own req.
module tb_bus_slave_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] data = '0;
    logic        out_ready = 1'b0;
    logic        req1 = 1'b0, req3 = 1'b0, req0 = 1'b0;

    logic        gnt1, ov1, pe1, gnt3, ov3, pe3, gnt0, ov0, pe0;
    logic [7:0]  oa1, oa3, oa0;
    logic [31:0] od1, od3, od0;
    logic [2:0]  lvl1, lvl3, lvl0;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    bus_slave_fifo #(.DEPTH(4), .GNT_DELAY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .addr(addr), .data(data), .gnt(gnt1),
        .out_valid(ov1), .out_ready(out_ready), .out_addr(oa1), .out_data(od1),
        .level(lvl1), .proto_err(pe1));

    bus_slave_fifo #(.DEPTH(4), .GNT_DELAY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .addr(addr), .data(data), .gnt(gnt3),
        .out_valid(ov3), .out_ready(out_ready), .out_addr(oa3), .out_data(od3),
        .level(lvl3), .proto_err(pe3));

    bus_slave_fifo #(.DEPTH(4), .GNT_DELAY(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .addr(addr), .data(data), .gnt(gnt0),
        .out_valid(ov0), .out_ready(out_ready), .out_addr(oa0), .out_data(od0),
        .level(lvl0), .proto_err(pe0));

    typedef struct {
        logic        req;
        logic [7:0]  a;
        logic [31:0] d;
        logic        rdy;
        logic        e_gnt;
        logic        e_ov;
        logic [7:0]  e_oa;
        logic [31:0] e_od;
        logic [2:0]  e_lvl;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic xfer1(input logic [7:0] a, input logic [31:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        req1 = 1'b1; addr = a; data = d;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (gnt1) ok = 1'b1;
        end
        @(negedge clk);
        req1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        bit got;
        int cyc, last_g, tx, rx;
        bit prev_g;

        // single write, then push+pop in the same cycle, then drain past empty
        vt[0]  = '{1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0};
        vt[1]  = '{1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0,        3'd0};
        vt[2]  = '{1'b1, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF, 3'd1};
        vt[3]  = '{1'b0, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF, 3'd1};
        vt[4]  = '{1'b1, 8'h34, 32'h11111111, 1'b0, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF, 3'd1};
        vt[5]  = '{1'b1, 8'h34, 32'h11111111, 1'b0, 1'b1, 1'b1, 8'h12, 32'hDEADBEEF, 3'd1};
        vt[6]  = '{1'b1, 8'h34, 32'h11111111, 1'b0, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF, 3'd2};
        vt[7]  = '{1'b1, 8'h56, 32'h22222222, 1'b0, 1'b0, 1'b1, 8'h12, 32'hDEADBEEF, 3'd2};
        vt[8]  = '{1'b1, 8'h56, 32'h22222222, 1'b0, 1'b1, 1'b1, 8'h12, 32'hDEADBEEF, 3'd2};
        vt[9]  = '{1'b1, 8'h56, 32'h22222222, 1'b1, 1'b0, 1'b1, 8'h34, 32'h11111111, 3'd2};
        vt[10] = '{1'b0, 8'h56, 32'h22222222, 1'b1, 1'b0, 1'b1, 8'h56, 32'h22222222, 3'd1};
        vt[11] = '{1'b0, 8'h56, 32'h22222222, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0};
        vt[12] = '{1'b0, 8'h56, 32'h22222222, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt",   32'(gnt1), 32'd0);
        chk("rst_valid", 32'(ov1),  32'd0);
        chk("rst_level", 32'(lvl1), 32'd0);
        chk("rst_perr",  32'(pe1),  32'd0);
        chk("rst_addr",  32'(oa1),  32'd0);
        chk("rst_data",  od1,       32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            req1 = vt[i].req; addr = vt[i].a; data = vt[i].d; out_ready = vt[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_gnt", i),   32'(gnt1), 32'(vt[i].e_gnt));
            chk($sformatf("vec%0d_valid", i), 32'(ov1),  32'(vt[i].e_ov));
            chk($sformatf("vec%0d_addr", i),  32'(oa1),  32'(vt[i].e_oa));
            chk($sformatf("vec%0d_data", i),  od1,       vt[i].e_od);
            chk($sformatf("vec%0d_level", i), 32'(lvl1), 32'(vt[i].e_lvl));
        end
        @(negedge clk);
        req1 = 1'b0; out_ready = 1'b0;

        // fill to DEPTH, fifth request stalls until one pop frees a slot
        for (int k = 0; k < 4; k++) begin
            xfer1(8'hA0 + 8'(k), 32'h1000 + 32'(k), ok);
            chk($sformatf("fill_gnt%0d", k), 32'(ok), 32'd1);
        end
        chk("fill_level", 32'(lvl1), 32'd4);
        chk("fill_head",  32'(oa1),  32'h0A0);
        req1 = 1'b1; addr = 8'hA4; data = 32'h1004;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("stall_gnt", 32'(gnt1), 32'd0);
        end
        chk("stall_level", 32'(lvl1), 32'd4);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pop_level", 32'(lvl1), 32'd3);
        chk("pop_head",  32'(oa1),  32'h0A1);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (gnt1) got = 1'b1;
        end
        chk("stall_release_gnt", 32'(got), 32'd1);
        @(negedge clk);
        req1 = 1'b0;
        chk("refill_level", 32'(lvl1), 32'd4);
        chk("refill_perr",  32'(pe1),  32'd0);

        // protocol error: req dropped after one cycle with a 3-cycle grant delay
        @(negedge clk);
        req3 = 1'b1; addr = 8'h77; data = 32'h77777777;
        @(negedge clk);
        req3 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("perr_no_gnt", 32'(gnt3), 32'd0);
        end
        chk("perr_level", 32'(lvl3), 32'd0);
        chk("perr_valid", 32'(ov3),  32'd0);
        chk("perr_set",   32'(pe3),  32'd1);
        repeat (5) @(negedge clk);
        chk("perr_sticky", 32'(pe3), 32'd1);

        // asynchronous reset with d1 in WAIT at level 3 and d0 holding gnt
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("prerst_level", 32'(lvl1), 32'd3);
        req1 = 1'b1; req0 = 1'b1; addr = 8'h99; data = 32'h99999999;
        @(posedge clk);
        #2;
        chk("prerst_gnt0", 32'(gnt0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_gnt0",  32'(gnt0), 32'd0);
        chk("arst_gnt1",  32'(gnt1), 32'd0);
        chk("arst_valid", 32'(ov1),  32'd0);
        chk("arst_level", 32'(lvl1), 32'd0);
        chk("arst_addr",  32'(oa1),  32'd0);
        chk("arst_perr3", 32'(pe3),  32'd0);
        req1 = 1'b0; req0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("arst_level0", 32'(lvl0), 32'd0);

        // zero-delay back-to-back transfers drained concurrently
        @(negedge clk);
        out_ready = 1'b1;
        tx = 0; rx = 0; cyc = 0; last_g = -1; prev_g = 1'b0;
        req0 = 1'b1; addr = 8'h80; data = 32'hA5A50000;
        while (rx < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (prev_g) begin
                tx++;
                if (tx < 8) begin
                    addr = 8'h80 + 8'(tx);
                    data = 32'hA5A50000 + 32'(tx);
                end else begin
                    req0 = 1'b0;
                end
            end
            if (ov0) begin
                chk($sformatf("b2b_addr%0d", rx), 32'(oa0), 32'h80 + 32'(rx));
                chk($sformatf("b2b_data%0d", rx), od0, 32'hA5A50000 + 32'(rx));
                rx++;
            end
            if (gnt0) begin
                if (last_g >= 0) chk("b2b_gap", 32'(cyc - last_g), 32'd2);
                last_g = cyc;
            end
            prev_g = gnt0;
        end
        chk("b2b_pushed",  32'(tx),   32'd8);
        chk("b2b_drained", 32'(rx),   32'd8);
        @(negedge clk);
        chk("b2b_level",   32'(lvl0), 32'd0);
        chk("b2b_perr",    32'(pe0),  32'd0);
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
